// File: rtl/osc_counter_pkg.sv
// Shared definitions for the parametrised oscillator counter: mode encodings
// and default geometry.
package osc_counter_pkg;

  localparam int DEFAULT_WIDTH = 20;
  localparam int DEFAULT_OUT_W = 8;

  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_MOD     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

endpackage

// File: rtl/osc_counter_param_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with n_rst, releases
// two rising clk edges after n_rst goes high.
module rst_sync (
  input  logic clk,
  input  logic n_rst,
  output logic rst_n_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_sync = sync_q[1];

endmodule

// File: rtl/osc_counter_param.sv
// Multi-mode oscillator counter with a clamped display window and a
// valid/ack snapshot port for tear-free reads of the full count.
module osc_counter_param
  import osc_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OUT_W = DEFAULT_OUT_W,
  parameter int TAP_W = $clog2(WIDTH - OUT_W + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [TAP_W-1:0] tap,
  input  logic             cap_req,
  input  logic             cap_ack,
  output logic [OUT_W-1:0] count_out,
  output logic             wrap,
  output logic             done,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_ovf
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [TAP_W-1:0] MAX_TAP  = TAP_W'(WIDTH - OUT_W);

  logic rst_int_n;

  rst_sync u_rst_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .rst_n_sync (rst_int_n)
  );

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] count_out_q, count_out_d;
  logic             cap_valid_q, cap_valid_d;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;
  logic             cap_ovf_q, cap_ovf_d;
  logic [TAP_W-1:0] tap_eff;
  mode_e            mode_s;

  assign mode_s  = mode_e'(mode);
  assign tap_eff = (tap > MAX_TAP) ? MAX_TAP : tap;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = (mode_s == MODE_ONESHOT) ? done_q : 1'b0;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en) begin
      case (mode_s)
        MODE_UP: begin
          cnt_d  = cnt_q + ONE;
          wrap_d = (cnt_q == ALL_ONES);
        end
        MODE_DOWN: begin
          cnt_d  = cnt_q - ONE;
          wrap_d = (cnt_q == '0);
        end
        MODE_MOD: begin
          if (cnt_q >= limit) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        MODE_ONESHOT: begin
          if (cnt_q < limit) begin
            cnt_d  = cnt_q + ONE;
            done_d = done_q | ((cnt_q + ONE) == limit);
          end else begin
            done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_out_d = cnt_q[tap_eff +: OUT_W];
  end

  // Snapshots take the pre-update count so a same-cycle clr still captures it.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_data_d  = cap_data_q;
    cap_ovf_d   = cap_ovf_q;
    if (cap_req) begin
      if (!cap_valid_q || cap_ack) begin
        cap_data_d  = cnt_q;
        cap_valid_d = 1'b1;
      end else begin
        cap_ovf_d = 1'b1;
      end
    end else if (cap_ack) begin
      cap_valid_d = 1'b0;
    end
    if (clr) begin
      cap_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      count_out_q <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      count_out_q <= count_out_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_ovf_q   <= cap_ovf_d;
    end
  end

  assign count_out = count_out_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign cap_ovf   = cap_ovf_q;

endmodule

// File: tb/tb_osc_counter_param.sv
// Directed bench for osc_counter_param: reset release, all four modes,
// window clamping and the capture handshake, with hand-computed expectations.
module tb_osc_counter_param;

  localparam int WIDTH = 20;
  localparam int OUT_W = 8;
  localparam int TAP_W = 4;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [TAP_W-1:0] tap;
  logic             cap_req;
  logic             cap_ack;
  logic [OUT_W-1:0] count_out;
  logic             wrap;
  logic             done;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_data;
  logic             cap_ovf;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [7:0] MOD_CO   [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2, 8'd3};
  localparam logic       MOD_WRAP [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] OS_CO    [5]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
  localparam logic       OS_DONE  [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  osc_counter_param #(.WIDTH(WIDTH), .OUT_W(OUT_W), .TAP_W(TAP_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .clr       (clr),
    .mode      (mode),
    .limit     (limit),
    .tap       (tap),
    .cap_req   (cap_req),
    .cap_ack   (cap_ack),
    .count_out (count_out),
    .wrap      (wrap),
    .done      (done),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .cap_ovf   (cap_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".count_out"}, 32'(count_out), 32'h0);
    check({tag, ".wrap"},      32'(wrap),      32'h0);
    check({tag, ".done"},      32'(done),      32'h0);
    check({tag, ".cap_valid"}, 32'(cap_valid), 32'h0);
    check({tag, ".cap_data"},  32'(cap_data),  32'h0);
    check({tag, ".cap_ovf"},   32'(cap_ovf),   32'h0);
  endtask

  initial begin
    n_rst   = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    mode    = 2'd0;
    limit   = '0;
    tap     = '0;
    cap_req = 1'b0;
    cap_ack = 1'b0;

    // Reset and release: two edges of synchroniser latency, then counting.
    repeat (3) tick();
    check_all_zero("rst");
    n_rst = 1'b1;
    tick();
    tick();
    check("rel.n2", 32'(count_out), 32'h0);
    tick();
    check("rel.n3", 32'(count_out), 32'h0);
    tick();
    check("rel.n4", 32'(count_out), 32'h1);
    tick();
    check("rel.n5", 32'(count_out), 32'h2);
    tick();
    check("rel.n6", 32'(count_out), 32'h3);

    // Modulo mode with limit 5, then limit lowered to 2 while the count is 4.
    clr   = 1'b1;
    mode  = 2'd2;
    limit = 20'd5;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("mod.co%0d", k + 1), 32'(count_out), 32'(MOD_CO[k]));
      check($sformatf("mod.wr%0d", k + 1), 32'(wrap), 32'(MOD_WRAP[k]));
    end
    limit = 20'd2;
    tick();
    check("modlow.wrap", 32'(wrap), 32'h1);
    check("modlow.co",   32'(count_out), 32'h4);
    tick();
    check("modlow.wrap2", 32'(wrap), 32'h0);
    check("modlow.co2",   32'(count_out), 32'h0);

    // ONESHOT, limit 3.
    clr   = 1'b1;
    mode  = 2'd3;
    limit = 20'd3;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("os.co%0d", k + 1),   32'(count_out), 32'(OS_CO[k]));
      check($sformatf("os.done%0d", k + 1), 32'(done), 32'(OS_DONE[k]));
      check($sformatf("os.wr%0d", k + 1),   32'(wrap), 32'h0);
    end
    clr = 1'b1;
    tick();
    check("os.clr_done", 32'(done), 32'h0);
    clr   = 1'b0;
    limit = 20'd0;
    tick();
    check("os.lim0_done", 32'(done), 32'h1);
    check("os.lim0_co",   32'(count_out), 32'h0);
    mode = 2'd0;
    en   = 1'b0;
    tick();
    check("os.modechg_done", 32'(done), 32'h0);

    // DOWN from 0 with the window tap clamped from 15 to 12.
    mode = 2'd1;
    en   = 1'b1;
    tap  = 4'd15;
    tick();
    check("down.wrap", 32'(wrap), 32'h1);
    en = 1'b0;
    tick();
    check("down.wrap2", 32'(wrap), 32'h0);
    check("down.co",    32'(count_out), 32'hFF);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hold.co%0d", k), 32'(count_out), 32'hFF);
    end
    cap_req = 1'b1;
    tick();
    check("down.cap_valid", 32'(cap_valid), 32'h1);
    check("down.cap_data",  32'(cap_data), 32'hFFFFF);
    cap_req = 1'b0;
    cap_ack = 1'b1;
    tick();
    check("ack.cap_valid", 32'(cap_valid), 32'h0);
    check("ack.cap_data",  32'(cap_data), 32'hFFFFF);
    cap_ack = 1'b0;

    // UP wrap from all-ones.
    mode = 2'd0;
    en   = 1'b1;
    tick();
    check("up.wrap", 32'(wrap), 32'h1);
    check("up.co",   32'(count_out), 32'hFF);
    tick();
    check("up.wrap2", 32'(wrap), 32'h0);
    check("up.co2",   32'(count_out), 32'h00);

    // Capture handshake.
    clr = 1'b1;
    tap = 4'd0;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    cap_req = 1'b1;
    tick();
    check("cap7.valid", 32'(cap_valid), 32'h1);
    check("cap7.data",  32'(cap_data), 32'd7);
    check("cap7.ovf",   32'(cap_ovf), 32'h0);
    tick();
    check("drop.ovf",   32'(cap_ovf), 32'h1);
    check("drop.data",  32'(cap_data), 32'd7);
    check("drop.valid", 32'(cap_valid), 32'h1);
    cap_req = 1'b0;
    repeat (11) tick();
    cap_req = 1'b1;
    cap_ack = 1'b1;
    tick();
    check("cap20.data",  32'(cap_data), 32'd20);
    check("cap20.valid", 32'(cap_valid), 32'h1);
    check("cap20.ovf",   32'(cap_ovf), 32'h1);
    clr = 1'b1;
    tick();
    check("capclr.data",  32'(cap_data), 32'd21);
    check("capclr.valid", 32'(cap_valid), 32'h1);
    check("capclr.ovf",   32'(cap_ovf), 32'h0);
    clr     = 1'b0;
    cap_req = 1'b0;
    cap_ack = 1'b0;

    // Asynchronous reset while a snapshot is pending.
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
